// File: rtl/sta_pkg.sv
// Shared definitions for the systolic tensor array result drain.
// Holds the default element widths, the drain FSM state type and the
// INT8 saturation limits used by the requantizer.
package sta_pkg;

    localparam int QUANTIZED_WIDTH = 8;
    localparam int ACC_WIDTH       = 4 * QUANTIZED_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    function automatic int sat_hi(input int qw);
        return (1 << (qw - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int qw);
        return -(1 << (qw - 1));
    endfunction

    localparam int SAT_MAX = sat_hi(QUANTIZED_WIDTH);
    localparam int SAT_MIN = sat_lo(QUANTIZED_WIDTH);

endpackage

// File: rtl/sta_result_drain_if.sv
// Output stream of the result drain: one requantized element per
// valid/ready transfer, tagged with its PE index and a last flag.
//   master : drain side (drives valid/data/idx/last, samples ready)
//   slave  : consumer side
interface sta_result_drain_if #(
    parameter int QUANTIZED_WIDTH = sta_pkg::QUANTIZED_WIDTH,
    parameter int IDX_WIDTH       = 2
);
    logic                              out_valid;
    logic                              out_ready;
    logic signed [QUANTIZED_WIDTH-1:0] out_data;
    logic        [IDX_WIDTH-1:0]       out_idx;
    logic                              out_last;

    modport master (
        output out_valid, out_data, out_idx, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_idx, out_last,
        output out_ready
    );
endinterface

// File: rtl/sta_requant.sv
// Combinational requantizer: signed accumulator -> signed QUANTIZED_WIDTH
// element using an arithmetic right shift with round-half-up and saturation.
//   acc_i   : signed accumulator value
//   shift_i : right-shift amount (0 = pass-through, no rounding)
//   q_o     : saturated result
module sta_requant
    import sta_pkg::*;
#(
    parameter int ACC_WIDTH       = sta_pkg::ACC_WIDTH,
    parameter int QUANTIZED_WIDTH = sta_pkg::QUANTIZED_WIDTH,
    parameter int SHIFT_WIDTH     = 5
) (
    input  logic        [ACC_WIDTH-1:0]       acc_i,
    input  logic        [SHIFT_WIDTH-1:0]     shift_i,
    output logic signed [QUANTIZED_WIDTH-1:0] q_o
);
    // One guard bit so that +max plus the rounding constant cannot wrap.
    localparam int EXT_W = ACC_WIDTH + 1;
    localparam logic signed [EXT_W-1:0] HI = EXT_W'(sat_hi(QUANTIZED_WIDTH));
    localparam logic signed [EXT_W-1:0] LO = EXT_W'(sat_lo(QUANTIZED_WIDTH));

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] shr;

    always_comb begin
        ext = $signed({acc_i[ACC_WIDTH-1], acc_i});
        rnd = '0;
        if (shift_i != '0) begin
            rnd = EXT_W'(1) << (shift_i - SHIFT_WIDTH'(1));
        end
        sum = ext + rnd;
        shr = sum >>> shift_i;
        if (shr > HI) begin
            q_o = HI[QUANTIZED_WIDTH-1:0];
        end else if (shr < LO) begin
            q_o = LO[QUANTIZED_WIDTH-1:0];
        end else begin
            q_o = shr[QUANTIZED_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/sta_result_drain.sv
// Result drain behind the PE row: captures all NUM_PE accumulators on
// tile_done_i, then streams requantized elements out over out_if.
//   clk_i, reset_n_i : clock, async active-low reset
//   tile_done_i      : pulse, acc_i/shift_i hold a finished tile
//   acc_i, shift_i   : PE results and requant shift
//   busy_o           : a tile is held/draining
//   overrun_o        : pulse, a tile_done_i was dropped
//   out_if           : element stream (master)
//
// state | meaning
// IDLE  | no tile held, out_valid low, waiting for tile_done_i
// DRAIN | tile held, element idx_q presented; a final transfer may
//       | coincide with a new tile_done_i and restart at idx 0
module sta_result_drain
    import sta_pkg::*;
#(
    parameter int NUM_PE          = 4,
    parameter int QUANTIZED_WIDTH = sta_pkg::QUANTIZED_WIDTH,
    parameter int ACC_WIDTH       = 4 * QUANTIZED_WIDTH,
    parameter int SHIFT_WIDTH     = $clog2(ACC_WIDTH),
    parameter int IDX_WIDTH       = $clog2(NUM_PE)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 tile_done_i,
    input  logic [NUM_PE-1:0][ACC_WIDTH-1:0]     acc_i,
    input  logic [SHIFT_WIDTH-1:0]               shift_i,
    output logic                                 busy_o,
    output logic                                 overrun_o,
    sta_result_drain_if.master                   out_if
);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PE - 1);

    drain_state_t                         state_q, state_d;
    logic [NUM_PE-1:0][ACC_WIDTH-1:0]     buf_q;
    logic [SHIFT_WIDTH-1:0]               shift_q;
    logic [IDX_WIDTH-1:0]                 idx_q, idx_d, idx_nxt;
    logic                                 valid_q, valid_d;
    logic                                 last_q, last_d;
    logic signed [QUANTIZED_WIDTH-1:0]    data_q, data_d;
    logic                                 overrun_q, overrun_d;

    logic                                 xfer, final_xfer, capture;
    logic [ACC_WIDTH-1:0]                 rq_acc;
    logic [SHIFT_WIDTH-1:0]               rq_shift;
    logic signed [QUANTIZED_WIDTH-1:0]    rq_q;

    assign xfer       = valid_q && out_if.out_ready;
    assign final_xfer = xfer && (idx_q == LAST_IDX);
    assign capture    = tile_done_i && ((state_q == IDLE) || final_xfer);
    assign idx_nxt    = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_WIDTH'(1);

    // A new tile's first element comes straight from acc_i so that it is
    // valid the cycle after capture; otherwise requantize the next buffered one.
    assign rq_acc   = capture ? acc_i[0] : buf_q[idx_nxt];
    assign rq_shift = capture ? shift_i  : shift_q;

    sta_requant #(
        .ACC_WIDTH       (ACC_WIDTH),
        .QUANTIZED_WIDTH (QUANTIZED_WIDTH),
        .SHIFT_WIDTH     (SHIFT_WIDTH)
    ) u_requant (
        .acc_i   (rq_acc),
        .shift_i (rq_shift),
        .q_o     (rq_q)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        overrun_d = 1'b0;
        if (capture) begin
            state_d = DRAIN;
            idx_d   = '0;
            valid_d = 1'b1;
            data_d  = rq_q;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                DRAIN: begin
                    overrun_d = tile_done_i;
                    if (final_xfer) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else if (xfer) begin
                        idx_d  = idx_nxt;
                        data_d = rq_q;
                        last_d = (idx_nxt == LAST_IDX);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
            if (capture) begin
                buf_q   <= acc_i;
                shift_q <= shift_i;
            end
        end
    end

    assign busy_o           = (state_q == DRAIN);
    assign overrun_o        = overrun_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_idx   = idx_q;
    assign out_if.out_last  = last_q;
endmodule

// File: tb/tb_sta_result_drain.sv
// Bench for sta_result_drain: directed scenarios plus a random phase,
// all compared cycle by cycle against a queue-based stream model.
module tb_sta_result_drain;
    localparam int NPE = 4;

    logic                    clk_i = 1'b0;
    logic                    reset_n_i;
    logic                    tile_done_i;
    logic [NPE-1:0][31:0]    acc_i;
    logic [4:0]              shift_i;
    logic                    busy_o;
    logic                    overrun_o;

    sta_result_drain_if #(.QUANTIZED_WIDTH(8), .IDX_WIDTH(2)) dif ();

    sta_result_drain #(.NUM_PE(NPE)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .tile_done_i (tile_done_i),
        .acc_i       (acc_i),
        .shift_i     (shift_i),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o),
        .out_if      (dif)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int data;
        int idx;
    } elem_t;

    elem_t exp_q[$];
    bit    ov_exp;
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference requantization: round half up, floor divide by 2^s, clamp.
    function automatic int requant_ref(input logic [31:0] a, input int s);
        longint v;
        v = longint'($signed(a));
        if (s > 0) v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        if (v > 127) return 127;
        if (v < -128) return -128;
        return int'(v);
    endfunction

    // One clock: update the model from the pre-edge inputs, then compare.
    task automatic step();
        bit mv   = (exp_q.size() > 0);
        bit xf   = mv && dif.out_ready;
        bit fin  = xf && (exp_q.size() == 1);
        @(posedge clk_i);
        ov_exp = 1'b0;
        if (xf) void'(exp_q.pop_front());
        if (tile_done_i) begin
            if (!mv || fin) begin
                for (int i = 0; i < NPE; i++)
                    exp_q.push_back('{requant_ref(acc_i[i], int'(shift_i)), i});
            end else begin
                ov_exp = 1'b1;
            end
        end
        #1;
        check("valid",   longint'(dif.out_valid), longint'(exp_q.size() > 0));
        check("busy",    longint'(busy_o),        longint'(exp_q.size() > 0));
        check("overrun", longint'(overrun_o),     longint'(ov_exp));
        if (exp_q.size() > 0) begin
            check("data", longint'($signed(dif.out_data)), longint'(exp_q[0].data));
            check("idx",  longint'(dif.out_idx),           longint'(exp_q[0].idx));
            check("last", longint'(dif.out_last),          longint'(exp_q[0].idx == NPE - 1));
        end else begin
            check("last_idle", longint'(dif.out_last), 0);
        end
    endtask

    task automatic tile(input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] a3, input int s);
        acc_i       = {a3, a2, a1, a0};
        shift_i     = 5'(s);
        tile_done_i = 1'b1;
        step();
        tile_done_i = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   longint'(dif.out_valid), 0);
        check({tag, "_data"},    longint'(dif.out_data),  0);
        check({tag, "_idx"},     longint'(dif.out_idx),   0);
        check({tag, "_last"},    longint'(dif.out_last),  0);
        check({tag, "_busy"},    longint'(busy_o),        0);
        check({tag, "_overrun"}, longint'(overrun_o),     0);
    endtask

    initial begin
        reset_n_i     = 1'b0;
        tile_done_i   = 1'b0;
        acc_i         = '0;
        shift_i       = '0;
        dif.out_ready = 1'b0;
        ov_exp        = 1'b0;
        #1;
        check_reset_outputs("rst0");
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // Basic drain with ready held high.
        dif.out_ready = 1'b1;
        tile(32'd100, -32'sd100, 32'd5000, -32'sd5000, 4);
        steps(5);

        // Backpressure at idx 1.
        tile(32'd100, -32'sd100, 32'd5000, -32'sd5000, 4);
        step();
        dif.out_ready = 1'b0;
        steps(3);
        dif.out_ready = 1'b1;
        steps(5);

        // Boundaries.
        tile(32'd127, -32'sd128, 32'd128, -32'sd129, 0);
        steps(5);
        tile(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1);
        steps(5);
        tile(32'h4000_0000, 32'h3FFF_FFFF, 32'hC000_0000, 32'h8000_0000, 31);
        steps(5);

        // Back-to-back tiles on the final transfer.
        tile(32'd100, -32'sd100, 32'd5000, -32'sd5000, 4);
        steps(3);
        tile(32'd16, 32'd32, 32'd48, 32'd64, 4);
        steps(5);

        // Overrun while idx 1 is presented.
        tile(32'd1000, 32'd2000, 32'd3000, 32'd4000, 5);
        step();
        tile(32'd7, 32'd7, 32'd7, 32'd7, 0);
        steps(5);

        // Reset in the middle of a drain.
        tile(32'd100, -32'sd100, 32'd5000, -32'sd5000, 4);
        step();
        reset_n_i = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_q.delete();
        ov_exp = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        steps(3);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            dif.out_ready = ($urandom_range(0, 9) < 7);
            tile_done_i   = ($urandom_range(0, 9) < 2);
            for (int i = 0; i < NPE; i++) begin
                if ($urandom_range(0, 1) == 1)
                    acc_i[i] = $urandom();
                else
                    acc_i[i] = 32'($urandom_range(0, 8000)) - 32'd4000;
            end
            shift_i = 5'($urandom_range(0, 31));
            step();
        end
        tile_done_i   = 1'b0;
        dif.out_ready = 1'b1;
        steps(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
